// File: rtl/div_sequencer.sv
// div_sequencer
// -------------
// Iterative signed divider controller for the multdiv unit. A start pulse
// either resolves a trivial case (zero divisor or zero dividend) in one cycle,
// or runs WIDTH steps of a restoring shift-subtract loop on the operand
// magnitudes. It then returns the sign-corrected quotient with a one-cycle
// ready pulse. The remainder is discarded.
//
// Handshake: ctrl_DIV is a single-cycle request. The operands are sampled on
// the same edge. It is accepted only while the sequencer is not running
// (IDLE or DONE). data_resultRDY is a one-cycle valid pulse with no
// back-pressure. data_result and data_exception are valid in that cycle and
// hold their values afterwards.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   ctrl_DIV        start pulse
//   data_operandA   dividend (two's complement)
//   data_operandB   divisor (two's complement)
//   data_result     quotient, registered
//   data_exception  divide-by-zero flag, registered
//   data_resultRDY  one-cycle result-valid pulse
//   busy            high while iterating
//   dbg_state       current FSM state (IDLE=0, RUN=1, DONE=2)

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;      // partial remainder, always < |B| <= 2^(WIDTH-1)
  logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   divb;     // |B|; one extra bit so |-2^(WIDTH-1)| fits
  logic             sign_q;

  // Magnitudes are taken in WIDTH+1 bits so the most negative value is
  // represented as a positive number.
  logic [WIDTH:0] mag_a;
  logic [WIDTH:0] mag_b;
  assign mag_a = data_operandA[WIDTH-1] ? -{1'b1, data_operandA} : {1'b0, data_operandA};
  assign mag_b = data_operandB[WIDTH-1] ? -{1'b1, data_operandB} : {1'b0, data_operandB};

  logic a_zero;
  logic b_zero;
  assign a_zero = (data_operandA == '0);
  assign b_zero = (data_operandB == '0);

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract. The comparison stands in for the sign of the trial
  // difference.
  logic [WIDTH:0]   shifted;
  logic             qbit;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;
  assign shifted = {rem, dvd[WIDTH-1]};
  assign qbit    = (shifted >= divb);
  assign q_next  = {dvd[WIDTH-2:0], qbit};
  // A quotient of 2^(WIDTH-1) with a positive sign wraps to the most
  // negative value. This is the documented overflow behaviour.
  assign q_final = sign_q ? -q_next : q_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      counter        <= '0;
      rem            <= '0;
      dvd            <= '0;
      divb           <= '0;
      sign_q         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (ctrl_DIV) begin
            if (b_zero) begin
              state          <= S_DONE;
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else if (a_zero) begin
              state          <= S_DONE;
              data_result    <= '0;
              data_exception <= 1'b0;
              data_resultRDY <= 1'b1;
            end else begin
              state   <= S_RUN;
              dvd     <= WIDTH'(mag_a);
              divb    <= mag_b;
              sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              rem     <= '0;
              counter <= '0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          rem     <= qbit ? WIDTH'(shifted - divb) : WIDTH'(shifted);
          dvd     <= q_next;
          counter <= counter + CW'(1);
          if (counter == CW'(WIDTH - 1)) begin
            state          <= S_DONE;
            data_result    <= q_final;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed cases from the test plan followed by
// randomized operations. The drivers push expected {exception, quotient} and
// the expected RDY cycle into queues. A monitor pops and compares them on
// every RDY pulse.

module tb_div_sequencer;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;
  logic [1:0]   dbg_state;

  div_sequencer #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];     // {exception, quotient}
  int         cyc_q[$];     // cycle in which RDY must be seen
  int         checks = 0;
  int         errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endfunction

  // Reference: signed division with wide integers, truncating toward zero.
  function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, q;
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == '0) return '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    return {1'b0, q[W-1:0]};
  endfunction

  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: RDY with nothing outstanding (cycle %0d) result 0x%0h",
                 cycle_cnt, data_result);
      end else begin
        logic [W:0] e;
        int         c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("result", 64'(data_result), 64'(e[W-1:0]));
        chk("exception", 64'(data_exception), 64'(e[W]));
        chk("rdy_cycle", 64'(cycle_cnt), 64'(c));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge. Drives a one-cycle start and records the expectation.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    exp_q.push_back(model(a, b));
    cyc_q.push_back(cycle_cnt + (((a == '0) || (b == '0)) ? 1 : 33));
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  // Returns at the negedge where RDY is seen, or reports a timeout.
  task automatic wait_rdy(input int budget);
    int k;
    k = 0;
    while (!data_resultRDY && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (!data_resultRDY) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: no RDY within %0d cycles (cycle %0d)", budget, cycle_cnt);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [W-1:0] pick();
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4, 5:    return W'($urandom_range(0, 200) - 100);
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int bcnt;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    idle(3);
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exception", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    idle(2);

    // Basic: 100 / 7, busy for exactly 32 cycles.
    start_op(32'd100, 32'd7);
    bcnt = 0;
    for (int k = 0; k < 40 && !data_resultRDY; k++) begin
      if (busy) bcnt++;
      @(negedge clock);
    end
    chk("busy_cycles", 64'(bcnt), 64'd32);
    chk("busy_at_rdy", 64'(busy), 64'd0);
    idle(3);
    chk("result_held", 64'(data_result), 64'd14);

    // Signs and overflow.
    start_op(-32'sd100, 32'd7);        wait_rdy(40); idle(1);
    start_op(32'd100, -32'sd7);        wait_rdy(40); idle(1);
    start_op(-32'sd100, -32'sd7);      wait_rdy(40); idle(1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF); wait_rdy(40); idle(1);

    // Zero cases.
    start_op(32'd1234, 32'd0);         wait_rdy(5);
    idle(2);
    chk("exception_held", 64'(data_exception), 64'd1);
    start_op(32'd0, 32'd5);            wait_rdy(5); idle(1);

    // Busy protection: a start during RUN must be ignored.
    start_op(32'd1000, 32'd10);
    idle(3);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy(40);

    // Back-to-back: start issued in the RDY cycle.
    start_op(32'd9, 32'd3);
    wait_rdy(40);
    start_op(32'd7, 32'd0);            // zero case straight after RDY
    wait_rdy(5);
    start_op(32'd50, 32'd5);           // normal op straight out of DONE
    wait_rdy(40); idle(1);

    // Reset mid-operation: aborted, no RDY for it.
    start_op(32'd1000, 32'd10);
    idle(9);
    reset = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    @(negedge clock);
    chk("midreset_result", 64'(data_result), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_exception", 64'(data_exception), 64'd0);
    reset = 1'b0;
    idle(40);                          // any stray RDY is flagged by the monitor
    start_op(32'd50, 32'd5);
    wait_rdy(40); idle(1);

    // Reset and start on the same edge: reset wins.
    reset         = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd0;
    @(negedge clock);
    chk("reset_wins_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_wins_exception", 64'(data_exception), 64'd0);
    reset    = 1'b0;
    ctrl_DIV = 1'b0;
    idle(3);

    // Randomized operations, sometimes back-to-back.
    for (int i = 0; i < 60; i++) begin
      start_op(pick(), pick());
      wait_rdy(40);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
    end
    idle(5);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative signed 32-bit divider controller for the processor's multdiv unit. It accepts a start pulse with operands and uses zero detection on both operands to short-circuit the trivial cases. Otherwise it sequences a 32-step restoring shift-subtract datapath and returns the quotient with a one-cycle ready pulse. Divide-by-zero is flagged as an exception for the writeback/exception stage.

## Interface
- WIDTH, 32, operand and quotient width; iteration count equals WIDTH.
- clock  in  1  rising-edge clock; one clock, all state on this edge.
- reset  in  1  synchronous, active-high; sampled on clock edge.
- ctrl_DIV  in  1  start pulse; operands sampled on same edge.
- data_operandA  in  WIDTH  dividend, two's complement.
- data_operandB  in  WIDTH  divisor, two's complement.
- data_result  out  WIDTH  quotient, registered, held until next accepted start.
- data_exception  out  1  divide-by-zero flag, registered, valid with data_resultRDY and held with data_result.
- data_resultRDY  out  1  one-cycle pulse, result valid.
- busy  out  1  high in RUN state.

## Operation
- States: IDLE, RUN, DONE.
- Reset:
  - Synchronous; forces IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0.
  - Aborts any operation in progress; no RDY pulse for the aborted operation.
- Start acceptance:
  - ctrl_DIV is accepted in IDLE and DONE.
  - ctrl_DIV in RUN is ignored; operands are not resampled.
- On an accepted start, classify the operands with full-width zero detects:
  - divisor == 0: go to DONE. data_result=0, data_exception=1.
  - else dividend == 0: go to DONE. data_result=0, data_exception=0.
  - else: latch |A|, |B| and sign = A[31]^B[31]. Clear the remainder and counter=0, then go to RUN.
- Magnitudes are taken with WIDTH+1-bit arithmetic, so that |−2^31| = 2^31 is represented.
- RUN, one step per cycle:
  - Shift {remainder, dividend} left by 1.
  - Trial = remainder − |B|.
  - If trial ≥ 0: remainder = trial and shift in quotient bit 1; else shift in 0.
  - counter increments; after step with counter == WIDTH−1, go to DONE.
- On leaving RUN:
  - data_result = sign ? −quotient : quotient, truncated to WIDTH bits.
  - Quotient truncates toward zero; the remainder is discarded.
  - data_exception=0.
- Overflow: −2^31 / −1 yields 0x80000000 (wraps), data_exception=0.
- DONE:
  - data_resultRDY=1 for exactly one cycle.
  - Next state is IDLE, or RUN/DONE if ctrl_DIV is asserted in that cycle, per the classification above.
- busy = (state == RUN).

## Timing
- E0 = the edge sampling an accepted ctrl_DIV.
- Zero-operand latency: data_resultRDY is high in the cycle after E0 (1 cycle).
- Normal latency:
  - RUN steps occur on edges E1..E32.
  - Result is registered at E32; data_resultRDY is high in the cycle after E32 (33 cycles from start).
  - busy is high from after E0 through E32.
- Back-to-back:
  - ctrl_DIV during the RDY cycle is accepted.
  - The new op's timing restarts from that edge; no idle bubble is required.
- Outputs change only on clock edges; no combinational path from inputs to outputs.
- reset and ctrl_DIV asserted on the same edge: reset wins.

## Test plan
- Basic: A=100, B=7, ctrl_DIV 1 cycle → RDY exactly 33 cycles later; result=14, exception=0; busy high for 32 cycles.
- Signs and overflow:
  - A=−100, B=7 → −14 (0xFFFFFFF2).
  - A=100, B=−7 → −14.
  - A=−100, B=−7 → 14.
  - A=0x80000000, B=0xFFFFFFFF → 0x80000000, exception=0.
- Zero cases:
  - B=0 (any A) → RDY next cycle; result=0, exception=1.
  - A=0, B=5 → RDY next cycle; result=0, exception=0.
- Busy protection: start A=1000, B=10, then pulse ctrl_DIV with A=1, B=1 at cycle 5 → ignored; RDY at cycle 33 with result=100.
- Back-to-back: assert ctrl_DIV with A=9, B=3 in the RDY cycle of a previous op → accepted; result=3 with RDY 33 cycles later.
- Reset mid-op: reset at cycle 10 of a RUN → all outputs 0, no RDY pulse; a fresh start A=50, B=5 then returns 10 at cycle 33.
